// File: rtl/irq_encoder16_if.sv
// Request/code bundle between peripheral request lines, the encoder and its consumer.
// The encoder takes the master side; the consumer/testbench takes the slave side.
interface irq_encoder16_if;
    logic [15:0] req;
    logic [15:0] mask;
    logic [3:0]  code_out;
    logic        code_valid;
    logic        code_ready;
    logic [15:0] pending_out;
    logic        any_pending;

    modport master (
        input  req, mask, code_ready,
        output code_out, code_valid, pending_out, any_pending
    );

    modport slave (
        output req, mask, code_ready,
        input  code_out, code_valid, pending_out, any_pending
    );
endinterface

// File: rtl/irq_encoder16.sv
// Registered 16-to-4 priority encoder with sticky request capture.
// Presents one pending, unmasked index at a time over valid/ready; clears it on accept.
module irq_encoder16 #(
    parameter int          LSB_FIRST = 1,
    parameter logic [15:0] MASK_RST  = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    irq_encoder16_if.master bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    if ((LSB_FIRST != 0 && LSB_FIRST != 1) || $bits(MASK_RST) != 16) begin : g_param_check
        $error("irq_encoder16: LSB_FIRST must be 0 or 1");
    end

    state_t      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [3:0]  code_q, code_d;
    logic [15:0] elig;
    logic [15:0] clr;
    logic [3:0]  sel;
    logic        accept;

    assign elig   = pending_q & bus.mask;
    assign accept = (state_q == HOLD) && bus.code_ready;
    assign clr    = accept ? (16'h0001 << code_q) : 16'h0000;

    // Later loop iterations overwrite earlier ones, so scan order sets priority.
    always_comb begin
        sel = 4'd0;
        if (LSB_FIRST != 0) begin
            for (int i = 15; i >= 0; i--) begin
                if (elig[i]) sel = 4'(i);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (elig[i]) sel = 4'(i);
            end
        end
    end

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        pending_d = (pending_q & ~clr) | bus.req;
        case (state_q)
            IDLE: begin
                if (elig != 16'h0000) begin
                    code_d  = sel;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous so it only acts on a clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 16'h0000;
            code_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
        end
    end

    assign bus.code_out    = code_q;
    assign bus.code_valid  = (state_q == HOLD);
    assign bus.pending_out = pending_q;
    assign bus.any_pending = |elig;

endmodule

// File: tb/tb_irq_encoder16.sv
// Self-checking bench for irq_encoder16: table-driven vectors for reset, single and multi request
// ordering (both priority directions), then directed sequences for backpressure, set-wins and reset.
module tb_irq_encoder16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic [15:0] mask;
    logic        code_ready;

    int n_checks = 0;
    int n_fail   = 0;

    irq_encoder16_if bus_l ();
    irq_encoder16_if bus_m ();

    assign bus_l.req        = req;
    assign bus_l.mask       = mask;
    assign bus_l.code_ready = code_ready;
    assign bus_m.req        = req;
    assign bus_m.mask       = mask;
    assign bus_m.code_ready = code_ready;

    irq_encoder16 #(.LSB_FIRST(1), .MASK_RST(16'hFFFF)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));
    irq_encoder16 #(.LSB_FIRST(0), .MASK_RST(16'hFFFF)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic [15:0] mask;
        logic        ready;
        logic [15:0] exp_pend;
        logic        exp_valid;
        logic [3:0]  exp_code;
        logic        exp_any;
        logic        exp_valid_m;
        logic [3:0]  exp_code_m;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [15:0] rq, input logic [15:0] m, input logic rdy);
        rst        = r;
        req        = rq;
        mask       = m;
        code_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_l(input string tag, input logic [15:0] p, input logic v,
                           input logic [3:0] c, input logic a);
        check({tag, " pending"}, 32'(bus_l.pending_out), 32'(p));
        check({tag, " valid"},   32'(bus_l.code_valid),  32'(v));
        check({tag, " code"},    32'(bus_l.code_out),    32'(c));
        check({tag, " any"},     32'(bus_l.any_pending), 32'(a));
    endtask

    initial begin
        //          rst   req       mask      rdy   pend      v     code   any   v_m   code_m
        vecs[0]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        vecs[1]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        vecs[2]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        vecs[3]  = '{1'b0, 16'h0400, 16'hFFFF, 1'b1, 16'h0400, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0};
        vecs[4]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h0400, 1'b1, 4'hA, 1'b1, 1'b1, 4'hA};
        vecs[5]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 4'hA, 1'b0, 1'b0, 4'hA};
        vecs[6]  = '{1'b0, 16'h8421, 16'hFFFF, 1'b1, 16'h8421, 1'b0, 4'hA, 1'b1, 1'b0, 4'hA};
        vecs[7]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h8421, 1'b1, 4'h0, 1'b1, 1'b1, 4'hF};
        vecs[8]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h8420, 1'b0, 4'h0, 1'b1, 1'b0, 4'hF};
        vecs[9]  = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h8420, 1'b1, 4'h5, 1'b1, 1'b1, 4'hA};
        vecs[10] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h8400, 1'b0, 4'h5, 1'b1, 1'b0, 4'hA};
        vecs[11] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h8400, 1'b1, 4'hA, 1'b1, 1'b1, 4'h5};
        vecs[12] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 4'hA, 1'b1, 1'b0, 4'h5};
        vecs[13] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h8000, 1'b1, 4'hF, 1'b1, 1'b1, 4'h0};
        vecs[14] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0};
        vecs[15] = '{1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 4'hF, 1'b0, 1'b0, 4'h0};

        rst = 1'b1; req = '0; mask = 16'hFFFF; code_ready = 1'b0;
        #2;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].mask, vecs[i].ready);
            check_l($sformatf("vec%0d", i), vecs[i].exp_pend, vecs[i].exp_valid,
                    vecs[i].exp_code, vecs[i].exp_any);
            check($sformatf("vec%0d msb valid", i), 32'(bus_m.code_valid), 32'(vecs[i].exp_valid_m));
            check($sformatf("vec%0d msb code", i),  32'(bus_m.code_out),   32'(vecs[i].exp_code_m));
        end
        check("msb pending drained", 32'(bus_m.pending_out), 32'h0);

        // Backpressure: code 4 held while mask drops and bit 0 arrives.
        step(1'b0, 16'h0010, 16'hFFFF, 1'b0);
        check_l("bp capture", 16'h0010, 1'b0, 4'hF, 1'b1);
        step(1'b0, 16'h0000, 16'hFFFF, 1'b0);
        check_l("bp present", 16'h0010, 1'b1, 4'h4, 1'b1);
        step(1'b0, 16'h0001, 16'h0000, 1'b0);
        check_l("bp hold0", 16'h0011, 1'b1, 4'h4, 1'b0);
        for (int i = 1; i < 5; i++) begin
            step(1'b0, 16'h0000, 16'h0000, 1'b0);
            check_l($sformatf("bp hold%0d", i), 16'h0011, 1'b1, 4'h4, 1'b0);
        end
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        check_l("bp accept", 16'h0001, 1'b0, 4'h4, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 16'h0000, 16'h0000, 1'b0);
            check_l($sformatf("bp masked%0d", i), 16'h0001, 1'b0, 4'h4, 1'b0);
        end
        step(1'b0, 16'h0000, 16'hFFFF, 1'b0);
        check_l("bp unmask", 16'h0001, 1'b1, 4'h0, 1'b1);

        // Set-wins: bit 3 re-requested on the accept edge stays pending.
        step(1'b0, 16'h0000, 16'hFFFF, 1'b1);
        check_l("sw drain0", 16'h0000, 1'b0, 4'h0, 1'b0);
        step(1'b0, 16'h0008, 16'hFFFF, 1'b0);
        check_l("sw capture", 16'h0008, 1'b0, 4'h0, 1'b1);
        step(1'b0, 16'h0000, 16'hFFFF, 1'b0);
        check_l("sw present", 16'h0008, 1'b1, 4'h3, 1'b1);
        step(1'b0, 16'h0008, 16'hFFFF, 1'b1);
        check_l("sw accept", 16'h0008, 1'b0, 4'h3, 1'b1);
        step(1'b0, 16'h0000, 16'hFFFF, 1'b0);
        check_l("sw represent", 16'h0008, 1'b1, 4'h3, 1'b1);

        // Reset while code 7 is held and ready is high: nothing is served.
        step(1'b0, 16'h0000, 16'hFFFF, 1'b1);
        check_l("rh drain3", 16'h0000, 1'b0, 4'h3, 1'b0);
        step(1'b0, 16'h0080, 16'hFFFF, 1'b0);
        check_l("rh capture", 16'h0080, 1'b0, 4'h3, 1'b1);
        step(1'b0, 16'h0000, 16'hFFFF, 1'b0);
        check_l("rh present", 16'h0080, 1'b1, 4'h7, 1'b1);
        step(1'b1, 16'h0000, 16'hFFFF, 1'b1);
        check_l("rh reset", 16'h0000, 1'b0, 4'h0, 1'b0);
        step(1'b0, 16'h0000, 16'hFFFF, 1'b1);
        check_l("rh idle", 16'h0000, 1'b0, 4'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
